ps2_rx_frame: RTL and testbench
===============================

# ps2_rx_frame

PS/2 device-to-host frame receiver for the keyboard control path. Synchronizes and deglitches the raw `ps2c`/`ps2d` pins and deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Presents each received scan-code byte on `dout` with a one-cycle `rx_done_tick`. It feeds the break-code (F0) detector and the scan-code decoder downstream.

## Interface
- `FILTER_LEN`, 8: `ps2c` debounce depth in `clk` cycles; legal range 2..16.
- `TIMEOUT_CYCLES`, 100000: idle-clock watchdog per bit (2 ms at 50 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `ps2c`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2d`  in  1  raw PS/2 data pin, asynchronous.
- `rx_en`  in  1  allows a new frame to start; sampled only in `idle`.
- `dout`  out  8  last good byte; holds until the next good frame.
- `rx_done_tick`  out  1  one-cycle pulse; `dout` is valid in the same cycle.
- `rx_err`  out  1  one-cycle pulse on a bad stop bit, parity error, or timeout.

## Operation
- Front end: 2-FF synchronizer on both pins. A `FILTER_LEN`-bit shift register samples synced `ps2c`.
  - Filtered clock goes 1 when all bits are 1 and goes 0 when all bits are 0. Otherwise it holds.
  - `fall_edge` is a one-cycle pulse on a filtered 1→0 transition.
- FSM states: `idle`, `dps` (data/parity/stop), `done`.
- `idle`:
  - On `fall_edge` with `rx_en`=1 and synced `ps2d`=0 (start bit) → `dps`. Load bit counter `n`=9; clear watchdog.
  - On `fall_edge` with `ps2d`=1 → ignore and stay in `idle`.
- `dps`: on each `fall_edge`, right-shift synced `ps2d` into the 10-bit register `b` (d0..d7, parity, stop → `b[9]` last). Reload the watchdog.
  - If `n`≠0: decrement `n`.
  - If `n`=0 (stop bit captured): go to `done`.
- `done`, one cycle, then always `idle`:
  - Stop=1 and parity OK: `dout`←`b[7:0]`; `rx_done_tick`=1.
  - Otherwise: `rx_err`=1; `dout` unchanged.
- Parity is odd: the XOR of d0..d7 and the parity bit must be 1.
- Watchdog: counts cycles in `dps` without a `fall_edge`. At `TIMEOUT_CYCLES`-1 → `idle` with `rx_err`=1; partial byte discarded.
- `rx_en` falling mid-frame does not abort; the current frame completes.
- Reset mid-frame: immediately `idle`; partial data discarded; no pulse.
- Reset values: `dout`=8'h00, `rx_done_tick`=0, `rx_err`=0, state `idle`, `n`=0, filter register all 1s, filtered clock 1.

## Timing
- Pin `ps2c` fall → `fall_edge`: 2 sync cycles + `FILTER_LEN` cycles, +1 register, i.e. `FILTER_LEN`+3 cycles.
- `ps2d` is sampled through the same 2-FF delay. PS/2 data is stable around the clock fall, so the skew is safe.
- `fall_edge` of the stop bit → `rx_done_tick`/`rx_err` asserted exactly 1 cycle later, for 1 cycle.
- `dout` changes only in the `rx_done_tick` cycle; it is stable for at least one full frame time after.
- `rx_done_tick` and `rx_err` are never high in the same cycle.
- Watchdog width: clog2(`TIMEOUT_CYCLES`) bits, saturating; no wrap-around.

## Configuration
- Macro `PS2_PARITY_CHECK_EN`.
- Defined: a parity mismatch in `done` produces `rx_err` and no `rx_done_tick`.
- Undefined: the parity bit is shifted in but ignored. Only the stop bit and the timeout can raise `rx_err`.

## Structure
- Shared package `ps2_pkg`:
  - State enum (`idle`, `dps`, `done`).
  - `PS2_FRAME_BITS`=11.
  - `PS2_BREAK_CODE`=8'hF0 and `PS2_EXT_CODE`=8'hE0, for downstream blocks.
- One sub-module, `ps2_edge_filter`: 2-FF sync plus debounce plus fall-edge pulse, parameterized by `FILTER_LEN`. Outputs `fall_edge` and synced data.

## Test plan
- Frame 0x1C, parity 0, stop 1, `rx_en`=1, bit period 3000 cycles → `dout`=8'h1C, `rx_done_tick` 1 cycle, `rx_err`=0.
- Frame 0xF0, parity 1, then frame 0x1C → two ticks; `dout`=8'hF0 then 8'h1C.
- With `PS2_PARITY_CHECK_EN`: 0x1C sent with parity 1 → `rx_err` pulse, no tick, `dout` keeps its prior value. Without the macro → tick, `dout`=8'h1C.
- `ps2c` glitch low for `FILTER_LEN`-1 cycles in `idle` and mid-frame → no bit consumed; frame still decodes correctly.
- Stop clocking after 5 bits → `rx_err` after `TIMEOUT_CYCLES` cycles, back to `idle`; next full 0x1C frame → tick.
- `reset` asserted mid-frame → outputs 0 next cycle. `rx_en`=0 at start bit → frame ignored, no pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding, frame geometry, well-known scan codes.
package ps2_pkg;

   typedef enum logic [1:0] {
      idle = 2'd0,
      dps  = 2'd1,
      done = 2'd2
   } ps2_state_e;

   localparam int PS2_FRAME_BITS = 11;

   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

   // Data bits plus parity bit must hold an odd number of ones.
   function automatic logic ps2_odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// PS/2 pin front end: 2-FF synchronizers on clock and data, all-ones/all-zeros
// debounce of the clock, and a one-cycle pulse on each filtered falling edge.
module ps2_edge_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c,
   input  logic ps2d,
   output logic fall_edge,
   output logic ps2d_sync
);

   logic                  c_meta_q, c_sync_q;
   logic                  d_meta_q, d_sync_q;
   logic [FILTER_LEN-1:0] filt_q, filt_d;
   logic                  fclk_q, fclk_d;
   logic                  fall_q, fall_d;

   always_comb begin
      filt_d = {c_sync_q, filt_q[FILTER_LEN-1:1]};
      fclk_d = fclk_q;
      if (&filt_q)
         fclk_d = 1'b1;
      else if (~|filt_q)
         fclk_d = 1'b0;
      fall_d = fclk_q & ~fclk_d;
   end

   // Synchronizers reset to the idle-high bus level so reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_meta_q <= 1'b1;
         c_sync_q <= 1'b1;
         d_meta_q <= 1'b1;
         d_sync_q <= 1'b1;
         filt_q   <= '1;
         fclk_q   <= 1'b1;
         fall_q   <= 1'b0;
      end else begin
         c_meta_q <= ps2c;
         c_sync_q <= c_meta_q;
         d_meta_q <= ps2d;
         d_sync_q <= d_meta_q;
         filt_q   <= filt_d;
         fclk_q   <= fclk_d;
         fall_q   <= fall_d;
      end
   end

   assign fall_edge = fall_q;
   assign ps2d_sync = d_sync_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB-first, odd parity, stop.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
//
// state | meaning
// idle  | waiting for a start bit (falling clock with data low) while rx_en is high
// dps   | shifting in d0..d7, parity and stop; watchdog armed between clock falls
// done  | one-cycle frame wrap-up; result pulse is already on the outputs
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2c,
   input  logic       ps2d,
   input  logic       rx_en,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       rx_err
);

   localparam int             WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam int             B_W     = PS2_FRAME_BITS - 1;

   logic fall_edge;
   logic d_sync;

   ps2_edge_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_edge_filter (
      .clk       (clk),
      .reset     (reset),
      .ps2c      (ps2c),
      .ps2d      (ps2d),
      .fall_edge (fall_edge),
      .ps2d_sync (d_sync)
   );

   ps2_state_e      state_q, state_d;
   logic [3:0]      n_q, n_d;
   logic [B_W-1:0]  b_q, b_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [7:0]      dout_q, dout_d;
   logic            tick_q, tick_d;
   logic            err_q, err_d;

   logic [B_W-1:0]  b_shift;
   logic            par_ok;

   assign b_shift = {d_sync, b_q[B_W-1:1]};

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ps2_odd_parity_ok(b_shift[8:0]);
`else
   assign par_ok = 1'b1;
`endif

   // The frame verdict is taken on the stop-bit edge so the pulse lands in the done cycle.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      b_d     = b_q;
      wd_d    = wd_q;
      dout_d  = dout_q;
      tick_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         idle: begin
            if (fall_edge && rx_en && !d_sync) begin
               state_d = dps;
               n_d     = 4'(PS2_FRAME_BITS - 2);
               b_d     = '0;
               wd_d    = '0;
            end
         end
         dps: begin
            if (fall_edge) begin
               b_d  = b_shift;
               wd_d = '0;
               if (n_q != 4'd0) begin
                  n_d = n_q - 4'd1;
               end else begin
                  state_d = done;
                  if (b_shift[B_W-1] && par_ok) begin
                     dout_d = b_shift[7:0];
                     tick_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end else if (wd_q == WD_LAST) begin
               state_d = idle;
               err_d   = 1'b1;
            end else if (wd_q != '1) begin
               wd_d = wd_q + 1'b1;
            end
         end
         done:    state_d = idle;
         default: state_d = idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= idle;
         n_q     <= '0;
         b_q     <= '0;
         wd_q    <= '0;
         dout_q  <= 8'h00;
         tick_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         b_q     <= b_d;
         wd_q    <= wd_d;
         dout_q  <= dout_d;
         tick_q  <= tick_d;
         err_q   <= err_d;
      end
   end

   assign dout         = dout_q;
   assign rx_done_tick = tick_q;
   assign rx_err       = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed scenarios plus random frames
// against a frame-level model of what the receiver must report.
module tb_ps2_rx_frame;

   localparam int FL      = 8;
   localparam int TIMEOUT = 5000;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       ps2c  = 1'b1;
   logic       ps2d  = 1'b1;
   logic       rx_en = 1'b1;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       rx_err;

   ps2_rx_frame #(
      .FILTER_LEN     (FL),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2c         (ps2c),
      .ps2d         (ps2d),
      .rx_en        (rx_en),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .rx_err       (rx_err)
   );

   always #5 clk = ~clk;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   int         tick_cnt = 0;
   int         err_cnt  = 0;
   int         both_cnt = 0;
   int         dout_bad = 0;
   logic [7:0] prev_dout = 8'h00;
   logic [7:0] exp_dout  = 8'h00;

   always @(negedge clk) begin
      if (rx_done_tick) tick_cnt++;
      if (rx_err) err_cnt++;
      if (rx_done_tick && rx_err) both_cnt++;
      if (!reset && !rx_done_tick && dout !== prev_dout) dout_bad++;
      prev_dout = dout;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives the first nbits of a frame; glitch_bit gets a sub-filter low pulse in its
   // high phase, drop_bit has rx_en removed just before its clock fall.
   task automatic send_bits(input logic [7:0] data, input logic par, input logic stop,
                            input int half, input int nbits, input int glitch_bit,
                            input int drop_bit);
      logic [10:0] fr;
      fr = {stop, par, data, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2d = fr[i];
         if (i == glitch_bit) begin
            wait_cyc(half / 2);
            ps2c = 1'b0;
            wait_cyc(FL - 1);
            ps2c = 1'b1;
            wait_cyc(half - half / 2 - (FL - 1));
         end else begin
            wait_cyc(half);
         end
         if (i == drop_bit) rx_en = 1'b0;
         ps2c = 1'b0;
         wait_cyc(half);
         ps2c = 1'b1;
      end
      wait_cyc(20);
      ps2d = 1'b1;
   endtask

   // Frame-level expectation: accepted frames update dout with a tick, received but
   // rejected frames give one error, ignored frames give nothing.
   task automatic do_frame(input string tag, input logic [7:0] data, input logic par,
                           input logic stop, input int half, input bit accepted_start,
                           input int glitch_bit, input int drop_bit);
      int  t0, e0;
      bit  good;
      t0 = tick_cnt;
      e0 = err_cnt;
      send_bits(data, par, stop, half, 11, glitch_bit, drop_bit);
      rx_en = 1'b1;
      good = stop && (!PAR_CHK || ((^data) ^ par));
      if (accepted_start && good) exp_dout = data;
      chk({tag, "_tick"}, tick_cnt - t0, (accepted_start && good) ? 1 : 0);
      chk({tag, "_err"}, err_cnt - e0, (accepted_start && !good) ? 1 : 0);
      chk({tag, "_dout"}, dout, exp_dout);
   endtask

   initial begin
      int t0, e0;
      logic [7:0] d;
      logic p, s;

      wait_cyc(5);
      chk("rst_dout", dout, 8'h00);
      chk("rst_tick", rx_done_tick, 1'b0);
      chk("rst_err", rx_err, 1'b0);
      reset = 1'b0;
      wait_cyc(30);

      do_frame("f1c_slow", 8'h1C, 1'b0, 1'b1, 1500, 1, -1, -1);
      do_frame("f_f0", 8'hF0, 1'b1, 1'b1, 80, 1, -1, -1);
      do_frame("f_1c", 8'h1C, 1'b0, 1'b1, 80, 1, -1, -1);
      do_frame("badpar", 8'h1C, 1'b1, 1'b1, 80, 1, -1, -1);
      do_frame("badstop", 8'h5A, ~^8'h5A, 1'b0, 80, 1, -1, -1);

      // glitch while idle, then a glitch inside a frame
      t0 = tick_cnt;
      e0 = err_cnt;
      ps2c = 1'b0;
      wait_cyc(FL - 1);
      ps2c = 1'b1;
      wait_cyc(50);
      chk("glitch_idle_tick", tick_cnt - t0, 0);
      chk("glitch_idle_err", err_cnt - e0, 0);
      do_frame("glitch_mid", 8'hA7, ~^8'hA7, 1'b1, 80, 1, 4, -1);

      // stall after 5 bits
      t0 = tick_cnt;
      e0 = err_cnt;
      send_bits(8'h33, 1'b1, 1'b1, 80, 5, -1, -1);
      wait_cyc(TIMEOUT + 100);
      chk("timeout_err", err_cnt - e0, 1);
      chk("timeout_tick", tick_cnt - t0, 0);
      chk("timeout_dout", dout, exp_dout);
      do_frame("after_to", 8'h1C, 1'b0, 1'b1, 80, 1, -1, -1);

      // receiver disabled for a whole frame
      rx_en = 1'b0;
      do_frame("rx_dis", 8'h55, ~^8'h55, 1'b1, 80, 0, -1, -1);
      rx_en = 1'b1;
      do_frame("en_drop", 8'h6B, ~^8'h6B, 1'b1, 80, 1, -1, 3);

      // reset in the middle of a frame
      t0 = tick_cnt;
      e0 = err_cnt;
      send_bits(8'h3A, ~^8'h3A, 1'b1, 80, 4, -1, -1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_dout", dout, 8'h00);
      chk("midrst_tick", rx_done_tick, 1'b0);
      chk("midrst_err", rx_err, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      exp_dout = 8'h00;
      wait_cyc(30);
      chk("midrst_no_pulse", (tick_cnt - t0) + (err_cnt - e0), 0);
      do_frame("after_rst", 8'h1C, 1'b0, 1'b1, 80, 1, -1, -1);

      for (int k = 0; k < 10; k++) begin
         d = 8'($urandom_range(0, 255));
         p = ~^d;
         if ($urandom_range(0, 4) == 0) p = ~p;
         s = ($urandom_range(0, 5) != 0);
         do_frame("rand", d, p, s, 80, 1, ($urandom_range(0, 3) == 0) ? 2 : -1, -1);
      end

      chk("never_both", both_cnt, 0);
      chk("dout_stable", dout_bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
